// File: rtl/booth_seq_divider_if.sv
// Handshake bundle for booth_seq_divider.
// Request side carries operands; response side carries result and flags.
interface booth_seq_divider_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] dividend;
  logic [WIDTH-1:0]   divisor;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   remainder;
  logic               ovf;
  logic               dbz;
  logic               busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder,
    input  ovf, dbz, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder,
    output ovf, dbz, busy
  );
endinterface

// File: rtl/booth_seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's complement operands.
module booth_seq_divider #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  booth_seq_divider_if.slave io
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   q_r;
  logic [WIDTH-1:0]   r_r;
  logic               ovf_r;
  logic               dbz_r;
  logic               accept;

  logic [2*WIDTH-1:0] dmag;
  logic [WIDTH-1:0]   vmag;
  logic [WIDTH+1:0]   sh;
  logic [WIDTH:0]     diff;
  logic               borrow;
  logic [WIDTH-1:0]   qs;
  logic [WIDTH-1:0]   rs;
  logic               ovf_fix;

`ifdef DIV_SIGNED_EN
  logic sd;
  logic sv;
  logic negq;
  localparam logic [WIDTH-1:0] LIM = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  assign accept = io.in_valid & io.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    io.busy      = 1'b0;
    unique case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_n = CALC;
      end
      CALC: begin
        io.busy = 1'b1;
        if (cnt == '0) state_n = FIX;
      end
      FIX: begin
        io.busy = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands are reduced to magnitudes up front; signs are reapplied in FIX.
  always_comb begin
    dmag = io.dividend;
    vmag = io.divisor;
`ifdef DIV_SIGNED_EN
    if (io.dividend[2*WIDTH-1]) dmag = -io.dividend;
    if (io.divisor[WIDTH-1])    vmag = -io.divisor;
`endif
  end

  always_comb begin
    sh     = {rem, quo[WIDTH-1]};
    borrow = sh < {2'b00, dvs};
    diff   = sh[WIDTH:0] - {1'b0, dvs};
  end

  always_comb begin
    qs      = quo;
    rs      = rem[WIDTH-1:0];
    ovf_fix = ovf_r;
`ifdef DIV_SIGNED_EN
    negq = sd ^ sv;
    if (negq) qs = -quo;
    if (sd)   rs = -rem[WIDTH-1:0];
    // Negative results may reach -2^(W-1); positive ones stop one short.
    if (negq) ovf_fix = ovf_r | (quo > LIM);
    else      ovf_fix = ovf_r | (quo >= LIM);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_r   <= '0;
      r_r   <= '0;
      ovf_r <= 1'b0;
      dbz_r <= 1'b0;
`ifdef DIV_SIGNED_EN
      sd    <= 1'b0;
      sv    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CW'(WIDTH-1);
            rem   <= {1'b0, dmag[2*WIDTH-1:WIDTH]};
            quo   <= dmag[WIDTH-1:0];
            dvs   <= vmag;
            ovf_r <= dmag[2*WIDTH-1:WIDTH] >= vmag;
            dbz_r <= io.divisor == '0;
`ifdef DIV_SIGNED_EN
            sd    <= io.dividend[2*WIDTH-1];
            sv    <= io.divisor[WIDTH-1];
`endif
          end
        end
        CALC: begin
          rem <= borrow ? sh[WIDTH:0] : diff;
          quo <= {quo[WIDTH-2:0], ~borrow};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          q_r   <= ovf_fix ? '1 : qs;
          r_r   <= ovf_fix ? '0 : rs;
          ovf_r <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign io.quotient  = q_r;
  assign io.remainder = r_r;
  assign io.ovf       = io.out_valid & ovf_r;
  assign io.dbz       = io.out_valid & dbz_r;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for booth_seq_divider, WIDTH=8.
// Signed expectations apply when DIV_SIGNED_EN is defined.
module tb_booth_seq_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_seq_divider_if #(.WIDTH(W)) bus ();

  booth_seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic start_op(input logic [15:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic take();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic run(input logic [15:0] a, input logic [7:0] b,
                     output logic [7:0] q, output logic [7:0] r,
                     output logic o, output logic z, output int lat);
    start_op(a, b);
    wait_out(lat);
    q = bus.quotient;
    r = bus.remainder;
    o = bus.ovf;
    z = bus.dbz;
    take();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_hs got=%b exp=100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    checks++;
    if ({bus.quotient, bus.remainder, bus.ovf, bus.dbz} !== 18'h0) begin
      errors++;
      $display("FAIL reset_out q=%h r=%h o=%b z=%b exp=0",
               bus.quotient, bus.remainder, bus.ovf, bus.dbz);
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_vectors(input string name,
                              input logic [15:0] a, input logic [7:0] b,
                              input logic [7:0] eq, input logic [7:0] er,
                              input logic eo, input logic ez);
    logic [7:0] q, r;
    logic o, z;
    int lat;
    run(a, b, q, r, o, z, lat);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL %s_lat got=%0d exp=%0d", name, lat, W + 1);
    end
    checks++;
    if ({q, r} !== {eq, er}) begin
      errors++;
      $display("FAIL %s_qr got=%h/%h exp=%h/%h", name, q, r, eq, er);
    end
    checks++;
    if ({o, z} !== {eo, ez}) begin
      errors++;
      $display("FAIL %s_flags ovf/dbz got=%b%b exp=%b%b",
               name, o, z, eo, ez);
    end
  endtask

  task automatic test_unsigned();
    test_vectors("u_basic", 16'h0FA6, 8'h4B, 8'h35, 8'h1F, 1'b0, 1'b0);
    test_vectors("u_zero",  16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
    test_vectors("u_max",   16'h04FF, 8'h05, 8'hFF, 8'h04, 1'b0, 1'b0);
  endtask

  task automatic test_dbz();
    test_vectors("dbz", 16'h1234, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_ovf();
    test_vectors("ovf_eq", 16'h1234, 8'h12, 8'hFF, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_signed();
`ifdef DIV_SIGNED_EN
    test_vectors("s_neg",  16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0);
    test_vectors("s_min",  16'hFC00, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0);
    test_vectors("s_pmax", 16'h0400, 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0);
`else
    test_vectors("s_neg",  16'hFF9C, 8'h07, 8'hFF, 8'h00, 1'b1, 1'b0);
    test_vectors("s_min",  16'hFC00, 8'h08, 8'hFF, 8'h00, 1'b1, 1'b0);
    test_vectors("s_pmax", 16'h0400, 8'h08, 8'h80, 8'h00, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(16'h0FA6, 8'h4B);
    wait_out(lat);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL bp_lat got=%0d exp=%0d", lat, W + 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.dividend = 16'h1234;
      bus.divisor  = 8'h12;
      @(posedge clk);
      #1;
      checks++;
      if ({bus.quotient, bus.remainder, bus.ovf, bus.dbz,
           bus.out_valid, bus.in_ready} !== {8'h35, 8'h1F, 4'b0010}) begin
        errors++;
        $display("FAIL bp_hold%0d q=%h r=%h o=%b z=%b ov=%b ir=%b",
                 i, bus.quotient, bus.remainder, bus.ovf, bus.dbz,
                 bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    take();
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release ir/ov got=%b exp=10",
               {bus.in_ready, bus.out_valid});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_ignored busy/ir got=%b exp=01",
               {bus.busy, bus.in_ready});
    end
  endtask

  task automatic test_reset_mid();
    start_op(16'h0FA6, 8'h4B);
    checks++;
    if ({bus.busy, bus.in_ready, bus.out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL calc_hs busy/ir/ov got=%b exp=100",
               {bus.busy, bus.in_ready, bus.out_valid});
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid ir/ov/busy got=%b exp=100",
               {bus.in_ready, bus.out_valid, bus.busy});
    end
    @(negedge clk) rst = 1'b0;
    test_vectors("after_rst", 16'h0FA6, 8'h4B, 8'h35, 8'h1F, 1'b0, 1'b0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    test_reset();
    test_unsigned();
    test_dbz();
    test_ovf();
    test_signed();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
